// File: rtl/bitsim_pkg.sv
// Shared types for the essential-bit datapath: mask/index widths and serializer states.
package bitsim_pkg;

    localparam int MASK_W = 16;
    localparam int IDX_W  = 4;

    typedef logic [MASK_W-1:0] mask_t;
    typedef logic [IDX_W-1:0]  idx_t;

    typedef enum logic {SER_IDLE, SER_BUSY} ser_state_e;

    // Index 0 maps to the MSB, so a right shift of this constant gives onehot(idx).
    localparam mask_t MSB_ONEHOT = mask_t'(1) << (MASK_W - 1);

endpackage

// File: rtl/bitmask_serializer_if.sv
// Word-in / index-beat-out handshake bundle for bitmask_serializer.
// The slave side is the serializer; the master side is whoever feeds it and drains it.
interface bitmask_serializer_if
    import bitsim_pkg::*;
#(
    parameter int TAG_W = 8
) ();

    logic             in_valid;
    logic             in_ready;
    mask_t            in_mask;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    idx_t             out_idx;
    logic             out_last;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero, out_tag
    );

    modport master (
        output in_valid, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero, out_tag
    );

endinterface

// File: rtl/lead_one_detect_16.sv
// Leading-one detector: bit15 -> 0 ... bit0 -> 15; an all-zero input reports index 0.
// Purely combinational, no backpressure.
module lead_one_detect_16
    import bitsim_pkg::*;
(
    input  mask_t mask,
    output idx_t  idx,
    output logic  is_zero
);

    always_comb begin
        idx     = '0;
        is_zero = (mask == '0);
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                idx = idx_t'(MASK_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bitmask_serializer.sv
// Serializes the set bits of a 16-bit mask, MSB first, as one 4-bit shift index per beat.
// First beat one cycle after accept, then one beat per cycle; out_ready stalls hold the beat.
// BITSER_ZERO_BEAT_EN: an all-zero word emits one out_zero beat instead of being dropped.
module bitmask_serializer
    import bitsim_pkg::*;
#(
    parameter int MAX_BITS = 16,
    parameter int TAG_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    bitmask_serializer_if.slave  bus
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BITS - 1);

    ser_state_e       state_q, state_d;
    mask_t            mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    idx_t  lead_idx;
    logic  lead_zero;
    mask_t mask_rest;
    logic  busy, out_valid, out_last, out_fire, in_ready, in_fire;

`ifdef BITSER_ZERO_BEAT_EN
    logic zero_q, zero_d;
`else
    logic zero_q;
    assign zero_q = 1'b0;
`endif

    lead_one_detect_16 u_lod (
        .mask    (mask_q),
        .idx     (lead_idx),
        .is_zero (lead_zero)
    );

    assign mask_rest = mask_q & ~(MSB_ONEHOT >> lead_idx);
    assign busy      = (state_q == SER_BUSY);
    assign out_valid = busy & (zero_q | ~lead_zero);
    // Last when only one bit remains, or the truncation budget is used up.
    assign out_last  = out_valid & (zero_q | (mask_rest == '0) | (cnt_q == CNT_LAST));
    assign out_fire  = out_valid & bus.out_ready;
    assign in_ready  = ~busy | (out_fire & out_last);
    assign in_fire   = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = lead_idx;
    assign bus.out_last  = out_last;
    assign bus.out_zero  = busy & zero_q;
    assign bus.out_tag   = tag_q;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
`ifdef BITSER_ZERO_BEAT_EN
        zero_d  = zero_q;
`endif
        if (out_fire) begin
            mask_d = mask_rest;
            cnt_d  = cnt_q + 1'b1;
            if (out_last) begin
                state_d = SER_IDLE;
                mask_d  = '0;
`ifdef BITSER_ZERO_BEAT_EN
                zero_d  = 1'b0;
`endif
            end
        end
        if (in_fire) begin
`ifdef BITSER_ZERO_BEAT_EN
            state_d = SER_BUSY;
            mask_d  = bus.in_mask;
            tag_d   = bus.in_tag;
            cnt_d   = '0;
            zero_d  = (bus.in_mask == '0);
`else
            // A zero word is swallowed here; the state left by the beat logic stands.
            if (bus.in_mask != '0) begin
                state_d = SER_BUSY;
                mask_d  = bus.in_mask;
                tag_d   = bus.in_tag;
                cnt_d   = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SER_IDLE;
            mask_q  <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

`ifdef BITSER_ZERO_BEAT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end
`endif

endmodule

// File: tb/tb_bitmask_serializer.sv
// Directed bench for bitmask_serializer: a MAX_BITS=16 instance and a MAX_BITS=4 instance.
module tb_bitmask_serializer;
    import bitsim_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bitmask_serializer_if #(.TAG_W(8)) bus  ();
    bitmask_serializer_if #(.TAG_W(8)) bus4 ();

    bitmask_serializer #(.MAX_BITS(16), .TAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    bitmask_serializer #(.MAX_BITS(4), .TAG_W(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // {in_ready, out_valid, out_idx, out_last, out_zero, out_tag}
    function automatic logic [15:0] exp_v(logic r, logic v, logic [3:0] i, logic l, logic z,
                                          logic [7:0] t);
        return {r, v, i, l, z, t};
    endfunction

    function automatic logic [15:0] obs_main();
        return {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero, bus.out_tag};
    endfunction

    function automatic logic [15:0] obs_four();
        return {bus4.in_ready, bus4.out_valid, bus4.out_idx, bus4.out_last, bus4.out_zero,
                bus4.out_tag};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;  bus.in_mask = '0;  bus.in_tag = '0;  bus.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_mask = '0; bus4.in_tag = '0; bus4.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 0, 0, 0, 0, 8'h00)) begin
            n_fail++;
            $display("FAIL reset_main: got %h want %h", obs_main(), exp_v(1, 0, 0, 0, 0, 8'h00));
        end
        n_checks++;
        if (obs_four() !== exp_v(1, 0, 0, 0, 0, 8'h00)) begin
            n_fail++;
            $display("FAIL reset_four: got %h want %h", obs_four(), exp_v(1, 0, 0, 0, 0, 8'h00));
        end
    endtask

    task automatic test_basic();
        logic [3:0]  idx_tab [3] = '{4'd0, 4'd2, 4'd15};
        logic [15:0] e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'hA001; bus.in_tag = 8'h11; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_accept: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            e = exp_v(k == 2, 1, idx_tab[k], k == 2, 0, 8'h11);
            n_checks++;
            if (obs_main() !== e) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h want %h", k, obs_main(), e);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_idle: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'h8000; bus.in_tag = 8'hA1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_mask = 16'h0100; bus.in_tag = 8'hB2;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 1, 0, 1, 0, 8'hA1)) begin
            n_fail++;
            $display("FAIL b2b_beat0: got %h want %h", obs_main(), exp_v(1, 1, 0, 1, 0, 8'hA1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 1, 7, 1, 0, 8'hB2)) begin
            n_fail++;
            $display("FAIL b2b_beat1: got %h want %h", obs_main(), exp_v(1, 1, 7, 1, 0, 8'hB2));
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_idle: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_truncate();
        logic [15:0] e;
        @(negedge clk);
        bus4.in_valid = 1'b1; bus4.in_mask = 16'hFFFF; bus4.in_tag = 8'hC3; bus4.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus4.in_valid = 1'b0;
            #1;
            e = exp_v(k == 3, 1, 4'(k), k == 3, 0, 8'hC3);
            n_checks++;
            if (obs_four() !== e) begin
                n_fail++;
                $display("FAIL trunc_beat%0d: got %h want %h", k, obs_four(), e);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus4.in_ready, bus4.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL trunc_idle: ready/valid %b want 10", {bus4.in_ready, bus4.out_valid});
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'h0300; bus.in_tag = 8'hD4; bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            // A different word offered during the stall must not be taken.
            bus.in_valid = 1'b1; bus.in_mask = 16'hFFFF; bus.in_tag = 8'hEE; bus.out_ready = 1'b0;
            #1;
            n_checks++;
            if (obs_main() !== exp_v(0, 1, 6, 0, 0, 8'hD4)) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h want %h", k, obs_main(),
                         exp_v(0, 1, 6, 0, 0, 8'hD4));
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(0, 1, 6, 0, 0, 8'hD4)) begin
            n_fail++;
            $display("FAIL stall_beat0: got %h want %h", obs_main(), exp_v(0, 1, 6, 0, 0, 8'hD4));
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 1, 7, 1, 0, 8'hD4)) begin
            n_fail++;
            $display("FAIL stall_beat1: got %h want %h", obs_main(), exp_v(1, 1, 7, 1, 0, 8'hD4));
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_idle: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_zero_word();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'h0000; bus.in_tag = 8'h55; bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_accept: in_ready %b want 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
`ifdef BITSER_ZERO_BEAT_EN
        n_checks++;
        if (obs_main() !== exp_v(1, 1, 0, 1, 1, 8'h55)) begin
            n_fail++;
            $display("FAIL zero_beat: got %h want %h", obs_main(), exp_v(1, 1, 0, 1, 1, 8'h55));
        end
        @(negedge clk); #1;
`endif
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_zero} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_idle: ready/valid/zero %b want 100",
                     {bus.in_ready, bus.out_valid, bus.out_zero});
        end
    endtask

    task automatic test_all_ones();
        logic [15:0] e;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'hFFFF; bus.in_tag = 8'h77; bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            e = exp_v(k == 15, 1, 4'(k), k == 15, 0, 8'h77);
            n_checks++;
            if (obs_main() !== e) begin
                n_fail++;
                $display("FAIL ones_beat%0d: got %h want %h", k, obs_main(), e);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ones_idle: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_reset_midword();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_mask = 16'hF800; bus.in_tag = 8'hE5; bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            n_checks++;
            if (obs_main() !== exp_v(0, 1, 4'(k), 0, 0, 8'hE5)) begin
                n_fail++;
                $display("FAIL rst_beat%0d: got %h want %h", k, obs_main(),
                         exp_v(0, 1, 4'(k), 0, 0, 8'hE5));
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 0, 0, 0, 0, 8'h00)) begin
            n_fail++;
            $display("FAIL rst_abort: got %h want %h", obs_main(), exp_v(1, 0, 0, 0, 0, 8'h00));
        end
        bus.in_valid = 1'b1; bus.in_mask = 16'h0001; bus.in_tag = 8'hF0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (obs_main() !== exp_v(1, 1, 15, 1, 0, 8'hF0)) begin
            n_fail++;
            $display("FAIL rst_newword: got %h want %h", obs_main(), exp_v(1, 1, 15, 1, 0, 8'hF0));
        end
        @(negedge clk); #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_idle: ready/valid %b want 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_truncate();
        test_stall();
        test_zero_word();
        test_all_ones();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
